ex_mem_stage: RTL and testbench

- Pipeline register between the execute stage (ALU, including the 16-bit RED reduction unit) and the memory stage.
- Captures the ALU result and control bits from EX each cycle.
- Owns the architectural N/V/Z flag register, updated per opcode from the ALU result.
- Supports stall, flush and sticky halt.

---
 rtl/ex_mem_if.sv | 36 +++
 rtl/ex_mem_stage.sv | 42 ++++
 tb/tb_ex_mem_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX-to-MEM pipeline bus with pipeline control, captured fields and architectural status.
interface ex_mem_if #(parameter int DW = 16, parameter int RW = 4);
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_alu_result;
  logic          ex_ovfl;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_wen;
  logic          ex_mem_wen;
  logic          ex_mem_ren;
  logic [DW-1:0] ex_store_data;
  logic          mem_valid;
  logic [3:0]    mem_opcode;
  logic [DW-1:0] mem_alu_result;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_wen;
  logic          mem_mem_wen;
  logic          mem_mem_ren;
  logic [DW-1:0] mem_store_data;
  logic [2:0]    flags;
  logic          halted;
  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_rd,
           ex_reg_wen, ex_mem_wen, ex_mem_ren, ex_store_data,
    input  mem_valid, mem_opcode, mem_alu_result, mem_rd, mem_reg_wen,
           mem_mem_wen, mem_mem_ren, mem_store_data, flags, halted
  );
  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_rd,
           ex_reg_wen, ex_mem_wen, ex_mem_ren, ex_store_data,
    output mem_valid, mem_opcode, mem_alu_result, mem_rd, mem_reg_wen,
           mem_mem_wen, mem_mem_ren, mem_store_data, flags, halted
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register owning the N/V/Z flags, with stall, flush and sticky halt.
module ex_mem_stage #(parameter int DW = 16, parameter int RW = 4) (
  input logic    clk,
  input logic    rst_n,
  ex_mem_if.slave b
);
  logic hold, take, arith, logic_op, zero;
  always_comb begin
    hold     = b.stall && !b.flush && !b.halted;
    take     = b.ex_valid && !b.stall && !b.flush && !b.halted;
    arith    = b.ex_opcode inside {4'h0, 4'h1};
    logic_op = b.ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6};
    zero     = ~|b.ex_alu_result;
  end
  // A halted stage ignores stall: it keeps loading bubbles until reset.
  always_ff @(posedge clk)
    if (!rst_n) begin
      b.mem_valid      <= 1'b0;
      b.mem_opcode     <= 4'h0;
      b.mem_alu_result <= {DW{1'b0}};
      b.mem_rd         <= {RW{1'b0}};
      b.mem_reg_wen    <= 1'b0;
      b.mem_mem_wen    <= 1'b0;
      b.mem_mem_ren    <= 1'b0;
      b.mem_store_data <= {DW{1'b0}};
      b.flags          <= 3'b000;
      b.halted         <= 1'b0;
    end else if (!hold) begin
      b.mem_valid      <= take;
      b.mem_opcode     <= take ? b.ex_opcode : 4'h0;
      b.mem_alu_result <= take ? b.ex_alu_result : {DW{1'b0}};
      b.mem_rd         <= take ? b.ex_rd : {RW{1'b0}};
      b.mem_reg_wen    <= take && b.ex_reg_wen;
      b.mem_mem_wen    <= take && b.ex_mem_wen;
      b.mem_mem_ren    <= take && b.ex_mem_ren;
      b.mem_store_data <= take ? b.ex_store_data : {DW{1'b0}};
      b.flags          <= !take ? b.flags :
                          arith ? {b.ex_alu_result[DW-1], b.ex_ovfl, zero} :
                          logic_op ? {b.flags[2:1], zero} : b.flags;
      b.halted         <= b.halted || (take && b.ex_opcode == 4'hF);
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table plus randomized run against a behavioural model.
module tb_ex_mem_stage;
  localparam logic O = 1'b0, I = 1'b1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_mem_if #(.DW(16), .RW(4)) bus ();
  ex_mem_stage #(.DW(16), .RW(4)) dut (.clk(clk), .rst_n(rst_n), .b(bus));

  typedef struct packed {
    logic rst_n, stall, flush, v;
    logic [3:0] op;
    logic [15:0] res;
    logic ovfl;
    logic [3:0] rd;
    logic rw, mw, mr;
    logic [15:0] sd;
    logic ev;
    logic [3:0] eop;
    logic [15:0] eres;
    logic [3:0] erd;
    logic erw, emw, emr;
    logic [15:0] esd;
    logic [2:0] ef;
    logic eh;
  } vec_t;
  vec_t vec [26];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input logic r, st, fl, v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic [3:0] rd, input logic rw, mw, mr, input logic [15:0] sd);
    rst_n = r; bus.stall = st; bus.flush = fl; bus.ex_valid = v; bus.ex_opcode = op;
    bus.ex_alu_result = res; bus.ex_ovfl = ov; bus.ex_rd = rd; bus.ex_reg_wen = rw;
    bus.ex_mem_wen = mw; bus.ex_mem_ren = mr; bus.ex_store_data = sd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural state updated from the priority rules.
  logic m_valid, m_rw, m_mw, m_mr, m_halted;
  logic [3:0] m_op, m_rd;
  logic [15:0] m_res, m_sd;
  logic m_n, m_v, m_z;

  task automatic model_edge;
    if (!rst_n) begin
      {m_valid, m_rw, m_mw, m_mr, m_halted, m_n, m_v, m_z} = '0;
      m_op = 0; m_rd = 0; m_res = 0; m_sd = 0;
    end else if (m_halted || bus.flush || (!bus.stall && !bus.ex_valid)) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    end else if (!bus.stall) begin
      m_valid = 1; m_op = bus.ex_opcode; m_res = bus.ex_alu_result; m_rd = bus.ex_rd;
      m_rw = bus.ex_reg_wen; m_mw = bus.ex_mem_wen; m_mr = bus.ex_mem_ren; m_sd = bus.ex_store_data;
      case (bus.ex_opcode)
        4'h0, 4'h1: begin
          m_n = bus.ex_alu_result[15]; m_v = bus.ex_ovfl; m_z = (bus.ex_alu_result == 0);
        end
        4'h2, 4'h4, 4'h5, 4'h6: m_z = (bus.ex_alu_result == 0);
        4'hF: m_halted = 1;
        default: ;
      endcase
    end
  endtask

  initial begin
    vec[0]  = '{O,O,O,I,4'h0,16'h1234,O,4'd1,I,O,O,16'h0000, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,O};
    vec[1]  = vec[0];
    vec[2]  = '{I,O,O,I,4'h0,16'h8000,O,4'd2,I,O,O,16'h0000, I,4'h0,16'h8000,4'd2,I,O,O,16'h0000,3'b100,O};
    vec[3]  = '{I,O,O,I,4'h2,16'h0000,O,4'd4,I,O,O,16'h0000, I,4'h2,16'h0000,4'd4,I,O,O,16'h0000,3'b101,O};
    vec[4]  = '{I,O,O,I,4'h3,16'h01BA,I,4'd3,I,O,O,16'h0000, I,4'h3,16'h01BA,4'd3,I,O,O,16'h0000,3'b101,O};
    vec[5]  = '{I,O,O,I,4'h0,16'h0000,I,4'd5,I,O,O,16'h0000, I,4'h0,16'h0000,4'd5,I,O,O,16'h0000,3'b011,O};
    vec[6]  = '{I,O,O,I,4'h1,16'h8001,O,4'd6,I,O,O,16'h0000, I,4'h1,16'h8001,4'd6,I,O,O,16'h0000,3'b100,O};
    vec[7]  = '{I,O,O,I,4'h0,16'h8000,I,4'd7,I,O,O,16'h0000, I,4'h0,16'h8000,4'd7,I,O,O,16'h0000,3'b110,O};
    vec[8]  = '{I,O,O,I,4'h2,16'h0000,I,4'd8,I,O,O,16'h0000, I,4'h2,16'h0000,4'd8,I,O,O,16'h0000,3'b111,O};
    vec[9]  = '{I,O,O,I,4'h8,16'h0040,I,4'd9,I,O,I,16'h0000, I,4'h8,16'h0040,4'd9,I,O,I,16'h0000,3'b111,O};
    vec[10] = '{I,O,O,I,4'h9,16'h0042,O,4'd0,O,I,O,16'hBEEF, I,4'h9,16'h0042,4'd0,O,I,O,16'hBEEF,3'b111,O};
    vec[11] = '{I,I,O,I,4'h0,16'h1234,O,4'd1,I,O,O,16'h0000, I,4'h9,16'h0042,4'd0,O,I,O,16'hBEEF,3'b111,O};
    vec[12] = vec[11];
    vec[13] = vec[11];
    vec[14] = '{I,O,O,I,4'h0,16'h1234,O,4'd1,I,O,O,16'h0000, I,4'h0,16'h1234,4'd1,I,O,O,16'h0000,3'b000,O};
    vec[15] = '{I,I,I,I,4'h0,16'h1234,O,4'd1,I,I,I,16'h5555, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,O};
    vec[16] = '{I,O,O,O,4'h1,16'h0000,I,4'd2,I,I,I,16'h0000, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,O};
    vec[17] = '{I,O,O,I,4'hF,16'h0000,O,4'd0,O,O,O,16'h0000, I,4'hF,16'h0000,4'd0,O,O,O,16'h0000,3'b000,I};
    vec[18] = '{I,O,O,I,4'h0,16'h0000,I,4'd1,I,O,O,16'h0000, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,I};
    vec[19] = '{I,I,O,I,4'h2,16'h0000,O,4'd1,I,I,O,16'h0000, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,I};
    vec[20] = '{O,O,O,I,4'h0,16'h1234,O,4'd1,I,O,O,16'h0000, O,4'h0,16'h0000,4'd0,O,O,O,16'h0000,3'b000,O};
    vec[21] = '{I,O,O,I,4'h0,16'h0000,O,4'd2,I,O,O,16'h0000, I,4'h0,16'h0000,4'd2,I,O,O,16'h0000,3'b001,O};
    vec[22] = '{I,O,O,I,4'h7,16'h8000,I,4'd3,I,O,O,16'h0000, I,4'h7,16'h8000,4'd3,I,O,O,16'h0000,3'b001,O};
    vec[23] = '{I,O,O,I,4'h4,16'h0001,O,4'd4,I,O,O,16'h0000, I,4'h4,16'h0001,4'd4,I,O,O,16'h0000,3'b000,O};
    vec[24] = '{I,O,O,I,4'h6,16'h0000,O,4'd5,I,O,O,16'h0000, I,4'h6,16'h0000,4'd5,I,O,O,16'h0000,3'b001,O};
    vec[25] = '{I,O,O,I,4'h5,16'h8000,I,4'd6,I,O,O,16'h0000, I,4'h5,16'h8000,4'd6,I,O,O,16'h0000,3'b000,O};

    drive(O, O, O, O, 4'h0, 16'h0, O, 4'd0, O, O, O, 16'h0);
    for (int i = 0; i < 26; i++) begin
      vec_t t = vec[i];
      drive(t.rst_n, t.stall, t.flush, t.v, t.op, t.res, t.ovfl, t.rd, t.rw, t.mw, t.mr, t.sd);
      step;
      chk($sformatf("v%0d valid", i), 32'(bus.mem_valid), 32'(t.ev));
      chk($sformatf("v%0d reg_wen", i), 32'(bus.mem_reg_wen), 32'(t.erw));
      chk($sformatf("v%0d mem_wen", i), 32'(bus.mem_mem_wen), 32'(t.emw));
      chk($sformatf("v%0d mem_ren", i), 32'(bus.mem_mem_ren), 32'(t.emr));
      chk($sformatf("v%0d flags", i), 32'(bus.flags), 32'(t.ef));
      chk($sformatf("v%0d halted", i), 32'(bus.halted), 32'(t.eh));
      if (t.ev || !t.rst_n) begin
        chk($sformatf("v%0d opcode", i), 32'(bus.mem_opcode), 32'(t.eop));
        chk($sformatf("v%0d result", i), 32'(bus.mem_alu_result), 32'(t.eres));
        chk($sformatf("v%0d rd", i), 32'(bus.mem_rd), 32'(t.erd));
        chk($sformatf("v%0d store", i), 32'(bus.mem_store_data), 32'(t.esd));
      end
    end

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      drive(i == 0 ? O : ($urandom_range(0, 99) >= 3), $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80, op,
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      model_edge;
      step;
      chk($sformatf("r%0d valid", i), 32'(bus.mem_valid), 32'(m_valid));
      chk($sformatf("r%0d wens", i), 32'({bus.mem_reg_wen, bus.mem_mem_wen, bus.mem_mem_ren}),
          32'({m_valid && m_rw, m_valid && m_mw, m_valid && m_mr}));
      chk($sformatf("r%0d flags", i), 32'(bus.flags), 32'({m_n, m_v, m_z}));
      chk($sformatf("r%0d halted", i), 32'(bus.halted), 32'(m_halted));
      if (m_valid) begin
        chk($sformatf("r%0d op/rd", i), 32'({bus.mem_opcode, bus.mem_rd}), 32'({m_op, m_rd}));
        chk($sformatf("r%0d data", i), {bus.mem_alu_result, bus.mem_store_data}, {m_res, m_sd});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
